// File: rtl/wshb_stream_pkg.sv
// Shared types and Wishbone constants for the stream-to-SDRAM writer.
package wshb_stream_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [3:0] SEL_ALL     = 4'hF;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a pop in the same cycle frees a slot for a push when full.
module sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_level;
   logic              w_push;
   logic              w_pop;

   assign empty  = (r_level == '0);
   assign full   = (r_level == (AW+1)'(DEPTH));
   assign level  = r_level;
   assign dout   = r_mem[r_rd_ptr];
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push & ~w_pop)      r_level <= r_level + 1'b1;
         else if (~w_push & w_pop) r_level <= r_level - 1'b1;
      end
   end

endmodule

// File: rtl/wshb_stream_writer.sv
// Buffers stream-master pixel words and writes them one at a time, classic Wishbone,
// to consecutive framebuffer addresses in SDRAM, wrapping at the end of each frame.
//
//   state | meaning
//   IDLE  | no SDRAM cycle; start one as soon as the FIFO holds a word
//   WRITE | m_cyc/m_stb up with FIFO head at the latched address, wait for m_ack
module wshb_stream_writer
   import wshb_stream_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
   parameter int          FRAME_WORDS = 800*480
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          s_cyc,
   input  logic                          s_stb,
   input  logic                          s_we,
   input  logic [31:0]                   s_dat_ms,
   output logic                          s_ack,
   output logic [31:0]                   s_dat_sm,
   output logic                          m_cyc,
   output logic                          m_stb,
   output logic                          m_we,
   output logic [31:0]                   m_adr,
   output logic [31:0]                   m_dat_ms,
   output logic [3:0]                    m_sel,
   output logic [2:0]                    m_cti,
   output logic [1:0]                    m_bte,
   input  logic                          m_ack,
   input  logic                          restart,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic [31:0] LAST_IDX = 32'(FRAME_WORDS - 1);

   state_t      r_state;
   logic [31:0] r_idx;
   logic [31:0] r_adr;
   logic        r_frame_done;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic [31:0] w_head;

   assign w_pop    = (r_state == WRITE) & m_ack;
   assign s_ack    = s_cyc & s_stb & (~s_we | ~w_full | w_pop);
   assign w_push   = s_ack & s_we;
   assign s_dat_sm = '0;

   sync_fifo #(
      .DATA_W (32),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .push    (w_push),
      .pop     (w_pop),
      .din     (s_dat_ms),
      .dout    (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_adr        <= BASE_ADR;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_pop & (r_idx == LAST_IDX);
         case (r_state)
            IDLE: begin
               // A restart landing on this edge already applies to the word being latched.
               if (~w_empty) begin
                  r_state <= WRITE;
                  r_adr   <= BASE_ADR + ((restart ? 32'd0 : r_idx) << 2);
               end
            end
            WRITE: begin
               if (m_ack) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         if (restart)    r_idx <= '0;
         else if (w_pop) r_idx <= (r_idx == LAST_IDX) ? 32'd0 : r_idx + 32'd1;
      end
   end

   assign m_cyc      = (r_state == WRITE);
   assign m_stb      = (r_state == WRITE);
   assign m_we       = 1'b1;
   assign m_adr      = r_adr;
   assign m_dat_ms   = w_head;
   assign m_sel      = SEL_ALL;
   assign m_cti      = CTI_CLASSIC;
   assign m_bte      = BTE_LINEAR;
   assign frame_done = r_frame_done;

endmodule
